// File: rtl/pease_stage_sequencer_if.sv
// Bundle of the frame handshakes and the stage-datapath bus around the
// Pease stage sequencer. The sequencer side drives ready/valid/result and the
// datapath operands. The environment side drives frames, downstream ready and
// the datapath result.
interface pease_stage_sequencer_if #(
  parameter int N_SAMPLES = 8,
  parameter int BIT_WIDTH = 32,
  parameter int SW        = 2
);
  logic                                recv_val;
  logic                                recv_rdy;
  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] recv_msg;
  logic                                send_val;
  logic                                send_rdy;
  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] send_msg;
  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] dp_in;
  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] dp_out;
  logic [SW-1:0]                       dp_stage;
  logic                                busy;

  modport master (
    input  recv_val, recv_msg, send_rdy, dp_out,
    output recv_rdy, send_val, send_msg, dp_in, dp_stage, busy
  );

  modport slave (
    output recv_val, recv_msg, send_rdy, dp_out,
    input  recv_rdy, send_val, send_msg, dp_in, dp_stage, busy
  );
endinterface

// File: rtl/pease_stage_sequencer.sv
// Frame-level controller for one shared Pease FFT stage datapath.
// It captures a frame and feeds it through the datapath LOG2N times, one
// stage index per pass. Each pass takes STAGE_LAT cycles. It then offers the
// frame downstream. In DONE it can hand off the result and take the next
// frame in the same cycle.
module pease_stage_sequencer #(
  parameter int N_SAMPLES = 8,
  parameter int BIT_WIDTH = 32,
  parameter int STAGE_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  pease_stage_sequencer_if.master io
);
  localparam int LOG2N = $clog2(N_SAMPLES);
  localparam int SW    = (LOG2N > 1) ? $clog2(LOG2N) : 1;
  localparam int WW    = (STAGE_LAT > 1) ? $clog2(STAGE_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t               state_reg;
  logic [BIT_WIDTH-1:0] buf_reg [N_SAMPLES];
  logic [SW-1:0]        stage_reg;
  logic [WW-1:0]        wcnt_reg;
  logic                 accept;

  // Ready is combinational from send_rdy so DONE can drain and refill in one cycle.
  // While reset is high, every handshake output is forced low.
  assign io.recv_rdy = !reset && ((state_reg == IDLE) ||
                                  ((state_reg == DONE) && io.send_rdy));
  assign io.send_val = !reset && (state_reg == DONE);
  assign io.busy     = !reset && (state_reg == COMPUTE);
  assign io.dp_stage = reset ? '0 : stage_reg;
  assign accept      = io.recv_val && io.recv_rdy;

  // The working buffer is both the datapath operand and the result frame.
  for (genvar gi = 0; gi < N_SAMPLES; gi++) begin : g_buf_out
    assign io.dp_in[gi]    = buf_reg[gi];
    assign io.send_msg[gi] = buf_reg[gi];
  end

  // Frame FSM: capture, recirculate through the stage datapath, present the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      stage_reg <= '0;
      wcnt_reg  <= '0;
      for (int i = 0; i < N_SAMPLES; i++) buf_reg[i] <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            for (int i = 0; i < N_SAMPLES; i++) buf_reg[i] <= io.recv_msg[i];
            stage_reg <= '0;
            wcnt_reg  <= '0;
            state_reg <= COMPUTE;
          end else if ((state_reg == DONE) && io.send_rdy) begin
            state_reg <= IDLE;
          end
        end
        COMPUTE: begin
          if (wcnt_reg == WW'(STAGE_LAT - 1)) begin
            // dp_out is valid on the last cycle of the pass.
            for (int i = 0; i < N_SAMPLES; i++) buf_reg[i] <= io.dp_out[i];
            wcnt_reg <= '0;
            if (stage_reg == SW'(LOG2N - 1)) begin
              state_reg <= DONE;
            end else begin
              stage_reg <= stage_reg + SW'(1);
            end
          end else begin
            wcnt_reg <= wcnt_reg + WW'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pease_stage_sequencer.sv
// Bench for pease_stage_sequencer. There are two instances. dut1 uses
// STAGE_LAT=1 with the ADD mock datapath. dut3 uses STAGE_LAT=3 with the
// STRIDE mock. Expected frames are queued when a frame is driven. They are
// compared when the DUT hands a result downstream.
module tb_pease_stage_sequencer;
  localparam int N     = 8;
  localparam int W     = 32;
  localparam int SW    = 2;
  localparam int LOG2N = 3;

  typedef logic [N-1:0][W-1:0] frame_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pease_stage_sequencer_if #(.N_SAMPLES(N), .BIT_WIDTH(W), .SW(SW)) io1 ();
  pease_stage_sequencer_if #(.N_SAMPLES(N), .BIT_WIDTH(W), .SW(SW)) io3 ();

  pease_stage_sequencer #(.N_SAMPLES(N), .BIT_WIDTH(W), .STAGE_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .io(io1)
  );
  pease_stage_sequencer #(.N_SAMPLES(N), .BIT_WIDTH(W), .STAGE_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .io(io3)
  );

  // ADD mock datapath
  always_comb begin
    io1.dp_out = '0;
    for (int i = 0; i < N; i++) io1.dp_out[i] = io1.dp_in[i] + W'(io1.dp_stage) + W'(1);
  end

  // STRIDE mock datapath
  always_comb begin
    io3.dp_out = '0;
    for (int i = 0; i < N / 2; i++) begin
      io3.dp_out[i]       = io3.dp_in[2*i];
      io3.dp_out[i + N/2] = io3.dp_in[2*i + 1];
    end
  end

  int     n_chk = 0;
  int     n_err = 0;
  int     sv_cnt1 = 0;
  frame_t q1[$];
  frame_t q3[$];

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic frame_t fill(input int v);
    frame_t f;
    for (int i = 0; i < N; i++) f[i] = W'(v);
    return f;
  endfunction

  function automatic frame_t ramp(input int a, input int b);
    frame_t f;
    for (int i = 0; i < N; i++) f[i] = W'(a * i + b);
    return f;
  endfunction

  function automatic frame_t add_model(input frame_t f);
    for (int s = 0; s < LOG2N; s++)
      for (int i = 0; i < N; i++) f[i] = f[i] + W'(s + 1);
    return f;
  endfunction

  function automatic frame_t stride_model(input frame_t f);
    frame_t g;
    for (int s = 0; s < LOG2N; s++) begin
      for (int i = 0; i < N / 2; i++) begin
        g[i]       = f[2*i];
        g[i + N/2] = f[2*i + 1];
      end
      f = g;
    end
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side of dut1: one line per completed transfer
  always @(negedge clk) begin
    if (io1.send_val === 1'b1) begin
      sv_cnt1++;
      if (io1.send_rdy === 1'b1) begin
        $display("[%0t] dut1 send %h", $time, io1.send_msg);
        if (q1.size() == 0) chk("sb1_unexpected", 256'(1), 256'(0));
        else chk("sb1_frame", io1.send_msg, q1.pop_front());
      end
    end
  end

  // Scoreboard side of dut3
  always @(negedge clk) begin
    if (io3.send_val === 1'b1 && io3.send_rdy === 1'b1) begin
      $display("[%0t] dut3 send %h", $time, io3.send_msg);
      if (q3.size() == 0) chk("sb3_unexpected", 256'(1), 256'(0));
      else chk("sb3_frame", io3.send_msg, q3.pop_front());
    end
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int sv_snap;
    frame_t fa, fb;
    reset = 1'b1;
    io1.recv_val = 1'b1; io1.recv_msg = '0; io1.send_rdy = 1'b1;
    io3.recv_val = 1'b1; io3.recv_msg = '0; io3.send_rdy = 1'b1;

    // 1. Reset for two cycles with recv_val high
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_rdy1", 256'(io1.recv_rdy), 256'(0));
      chk("rst_sval1", 256'(io1.send_val), 256'(0));
      chk("rst_busy1", 256'(io1.busy), 256'(0));
      chk("rst_stage1", 256'(io1.dp_stage), 256'(0));
      chk("rst_rdy3", 256'(io3.recv_rdy), 256'(0));
    end
    tick();
    reset = 1'b0; io1.recv_val = 1'b0; io3.recv_val = 1'b0;
    @(negedge clk);
    chk("rel_rdy1", 256'(io1.recv_rdy), 256'(1));
    chk("rel_rdy3", 256'(io3.recv_rdy), 256'(1));
    chk("rel_buf1", io1.send_msg, 256'(0));

    // 2. ADD, STAGE_LAT=1, all-zero frame
    tick();
    io1.recv_val = 1'b1; io1.recv_msg = fill(0); q1.push_back(add_model(fill(0)));
    @(negedge clk);
    chk("t2_acc", 256'(io1.recv_rdy), 256'(1));
    tick();
    io1.recv_val = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t2_busy", 256'(io1.busy), 256'(1));
      chk("t2_stage", 256'(io1.dp_stage), 256'(k));
      chk("t2_sval", 256'(io1.send_val), 256'(0));
      tick();
    end
    @(negedge clk);
    chk("t2_done", 256'(io1.send_val), 256'(1));
    chk("t2_busy_off", 256'(io1.busy), 256'(0));
    chk("t2_data", io1.send_msg, fill(6));
    tick();

    // 3. STRIDE, STAGE_LAT=3, ramp 0..7
    io3.recv_val = 1'b1; io3.recv_msg = ramp(1, 0); q3.push_back(stride_model(ramp(1, 0)));
    @(negedge clk);
    chk("t3_acc", 256'(io3.recv_rdy), 256'(1));
    tick();
    io3.recv_val = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk("t3_busy", 256'(io3.busy), 256'(1));
      chk("t3_stage", 256'(io3.dp_stage), 256'(k / 3));
      chk("t3_sval", 256'(io3.send_val), 256'(0));
      tick();
    end
    @(negedge clk);
    chk("t3_done", 256'(io3.send_val), 256'(1));
    chk("t3_busy_off", 256'(io3.busy), 256'(0));
    chk("t3_identity", io3.send_msg, ramp(1, 0));
    tick();

    // 4. Backpressure in DONE with recv_val held high
    fa = ramp(3, 1);
    fb = ramp(5, 100);
    io1.send_rdy = 1'b0;
    io1.recv_val = 1'b1; io1.recv_msg = fa; q1.push_back(add_model(fa));
    @(negedge clk);
    chk("t4_acc", 256'(io1.recv_rdy), 256'(1));
    tick();
    io1.recv_val = 1'b0;
    repeat (3) tick();
    io1.recv_val = 1'b1; io1.recv_msg = fb;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_sval", 256'(io1.send_val), 256'(1));
      chk("t4_rdy", 256'(io1.recv_rdy), 256'(0));
      chk("t4_busy", 256'(io1.busy), 256'(0));
      chk("t4_hold", io1.send_msg, add_model(fa));
      tick();
    end
    io1.send_rdy = 1'b1; q1.push_back(add_model(fb));
    @(negedge clk);
    chk("t4_xfer_rdy", 256'(io1.recv_rdy), 256'(1));
    tick();
    io1.recv_val = 1'b0;
    @(negedge clk);
    chk("t4_busy2", 256'(io1.busy), 256'(1));
    repeat (3) tick();
    @(negedge clk);
    chk("t4_done2", 256'(io1.send_val), 256'(1));
    tick();

    // 5. Back-to-back frames of 0s then 10s
    io1.recv_val = 1'b1; io1.recv_msg = fill(0); q1.push_back(add_model(fill(0)));
    @(negedge clk);
    chk("t5_acc0", 256'(io1.recv_rdy), 256'(1));
    tick();
    io1.recv_msg = fill(10); q1.push_back(add_model(fill(10)));
    repeat (3) tick();
    @(negedge clk);
    chk("t5_sval0", 256'(io1.send_val), 256'(1));
    chk("t5_rdy0", 256'(io1.recv_rdy), 256'(1));
    chk("t5_data0", io1.send_msg, fill(6));
    tick();
    io1.recv_val = 1'b0;
    @(negedge clk);
    chk("t5_nogap", 256'(io1.busy), 256'(1));
    chk("t5_sval_off", 256'(io1.send_val), 256'(0));
    repeat (3) tick();
    @(negedge clk);
    chk("t5_sval1", 256'(io1.send_val), 256'(1));
    chk("t5_data1", io1.send_msg, fill(16));
    tick();

    // 6. Reset while the frame is on stage 1
    io1.recv_val = 1'b1; io1.recv_msg = fill(5);
    @(negedge clk);
    chk("t6_acc", 256'(io1.recv_rdy), 256'(1));
    tick();
    io1.recv_val = 1'b0;
    tick();
    @(negedge clk);
    chk("t6_stage", 256'(io1.dp_stage), 256'(1));
    sv_snap = sv_cnt1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_busy", 256'(io1.busy), 256'(0));
    chk("t6_sval", 256'(io1.send_val), 256'(0));
    chk("t6_idle", 256'(io1.recv_rdy), 256'(1));
    chk("t6_buf", io1.send_msg, 256'(0));
    chk("t6_stage0", 256'(io1.dp_stage), 256'(0));
    repeat (6) tick();
    chk("t6_nosend", 256'(sv_cnt1 - sv_snap), 256'(0));

    chk("q1_left", 256'(q1.size()), 256'(0));
    chk("q3_left", 256'(q3.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
